axi_mem_responder: RTL and testbench
====================================

// Module: axi_mem_responder
// PURPOSE
//  AXI4 slave endpoint that terminates a full AXI4 master port (e.g. the m_ side of a clock
//  converter) on a local word-addressed register memory. Used as a bring-up/sim target and as a
//  small scratchpad behind a crossbar. Independent read and write engines, FIXED/INCR bursts.
//  One outstanding transaction per direction.
// PARAMETERS
//  LOCAL_DATA_WIDTH  32  bus/word width; 32, 64 or 512
//  LOCAL_ADDR_WIDTH  32  AXI address width
//  LOCAL_ID_WIDTH    2   AXI ID width
//  MEM_DEPTH         1024  words; power of two, >=2
// PORTS
//  s_axi_aclk     in   1    clock
//  s_axi_aresetn  in   1    asynchronous active-low reset
//  s_axi_aw*      in   AW:  id, addr, len[8], size[3], burst[2], lock, cache, prot, qos, region, valid
//  s_axi_awready  out  1    AW accept
//  s_axi_w*       in   W:   data[DW], strb[DW/8], last, valid
//  s_axi_wready   out  1    W accept
//  s_axi_b*       out  B:   id, resp[2], valid; s_axi_bready in 1
//  s_axi_ar*      in   AR:  same fields as AW
//  s_axi_arready  out  1    AR accept
//  s_axi_r*       out  R:   id, data[DW], resp[2], last, valid; s_axi_rready in 1
//  (port set = standard slave port macro with prefix s, LOCAL_* widths)
// BEHAVIOUR
//  Reset: awready/wready/bvalid/arready/rvalid/rlast = 0, bresp/rresp/rdata/ids = 0; memory NOT
//   reset. First cycle after deassertion: awready=arready=1. Reset mid-burst aborts, no B/R sent.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: awready=1; AW hs latches id/addr/len/size/burst -> W_DATA (awready=0).
//   W_DATA: wready=1; each W hs writes strb-enabled bytes to current word, advances addr;
//    beat with wlast (or beat len+1) -> W_RESP. wlast mismatch vs len: burst ends on beat len+1,
//    resp SLVERR.
//   W_RESP: bvalid=1 held until bready; B hs -> W_IDLE. Min AW->B latency: AW hs N, W hs N+1
//    (len=0), bvalid N+2.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   R_IDLE: arready=1; AR hs at N -> first rvalid at N+1 (registered data).
//   R_DATA: rvalid high every beat; data/resp/last held stable while rready=0; rlast on beat len.
//    Final R hs -> R_IDLE; arready=1 the next cycle.
//  Address gen: beat addr = FIXED: start; INCR: start + k*bytes (mod 2^ADDR_WIDTH, no 4KB check).
//   Word index = addr[ADDR_LSB +: log2(MEM_DEPTH)], ADDR_LSB = log2(DW/8); low bits ignored.
//  Errors (resp per beat for R, sticky worst-case for B; DECERR > SLVERR > OKAY):
//   addr >= MEM_DEPTH*DW/8 -> DECERR, write suppressed, rdata=0.
//   burst WRAP or 2'b11, or size != ADDR_LSB -> SLVERR for whole burst, no writes, rdata=0.
//  Same-cycle read and write of the same word: read returns old data; write lands.
//  Read and write engines fully concurrent; awlock/cache/prot/qos/region ignored.
// STRUCTURE
//  Shared AXI package: AXI_BURST_FIXED/INCR/WRAP, AXI_RESP_OKAY/SLVERR/DECERR, burst/resp typedefs.
//  Sub-module axi_mem_addr_gen (start addr, size, burst, len, step -> cur addr, beat cnt, last,
//   err), instantiated once for AW and once for AR.
//  Top holds both FSMs and the memory array (2 ports: 1 W byte-enable, 1 R).
// TESTING
//  1 Single write 0x10 data 0xDEADBEEF strb 0xF, then read 0x10 -> BRESP OKAY, RDATA 0xDEADBEEF, RLAST=1.
//  2 INCR len=3 write 0x100..0x10C data 1..4, INCR read len=3 -> R beats 1,2,3,4, rlast on beat 4 only.
//  3 FIXED len=3 write 0x20 data A,B,C,D -> read 0x20 returns D; strb 0x3 partial write merges bytes.
//  4 Read at MEM_DEPTH*DW/8 len=1 -> two R beats DECERR rdata 0; INCR straddling end -> OKAY then DECERR.
//  5 rready toggling 1/0 random, bready held low 10 cycles -> data stable, bvalid held, no lost beat.
//  6 Reset asserted mid write burst beat 2 of 4 -> bvalid never asserts; post-reset write/read OK.

Source files
------------

// File: rtl/axi_mem_responder_pkg.sv
// Shared AXI definitions for the memory responder: burst and response
// encodings, plus helpers to validate a burst and merge beat responses.
package axi_mem_responder_pkg;

   typedef logic [1:0] axi_burst_t;
   typedef logic [1:0] axi_resp_t;

   localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
   localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
   localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

   localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
   localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
   localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

   // Only FIXED/INCR at full bus width are serviced; anything else fails the whole burst.
   function automatic logic burst_err(input axi_burst_t burst, input logic [2:0] size,
                                      input logic [2:0] exp_size);
      return !((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR)) || (size != exp_size);
   endfunction

   // Encodings are ordered OKAY < SLVERR < DECERR, so the numeric max is the worst case.
   function automatic axi_resp_t resp_worst(input axi_resp_t a, input axi_resp_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Burst address generator, one per direction.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load latches a new burst
// (i_addr, i_size, i_burst, i_len); i_step advances one beat. o_addr is the current beat
// address, o_next_addr the following one, o_last/o_last_next flag the final beat for the
// current/next beat, o_err marks an unsupported burst type or size.
module axi_mem_addr_gen
   import axi_mem_responder_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int ADDR_LSB = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [2:0]        i_size,
   input  logic [1:0]        i_burst,
   input  logic [7:0]        i_len,
   input  logic              i_step,
   output logic [ADDR_W-1:0] o_addr,
   output logic [ADDR_W-1:0] o_next_addr,
   output logic              o_last,
   output logic              o_last_next,
   output logic              o_err
);

   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic [7:0]        r_len;
   logic [7:0]        r_cnt;
   logic              r_err;
   logic [ADDR_W-1:0] w_step;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr  <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else if (i_load) begin
         r_addr  <= i_addr;
         r_size  <= i_size;
         r_burst <= i_burst;
         r_len   <= i_len;
         r_cnt   <= '0;
         r_err   <= burst_err(i_burst, i_size, 3'(ADDR_LSB));
      end else if (i_step) begin
         r_addr  <= o_next_addr;
         r_cnt   <= r_cnt + 8'd1;
      end
   end

   // Address wraps modulo 2^ADDR_W; no 4KB boundary enforcement.
   assign w_step      = {{(ADDR_W-1){1'b0}}, 1'b1} << r_size;
   assign o_addr      = r_addr;
   assign o_next_addr = (r_burst == AXI_BURST_FIXED) ? r_addr : r_addr + w_step;
   assign o_last      = (r_cnt == r_len);
   assign o_last_next = ((r_cnt + 8'd1) == r_len);
   assign o_err       = r_err;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave terminating a full master port on a local word-addressed memory.
// Independent write (AW/W/B) and read (AR/R) engines, FIXED/INCR bursts, one outstanding
// transaction per direction. Out-of-range beats return DECERR, unsupported bursts SLVERR.
// Ports: s_axi_aclk/s_axi_aresetn clock and async active-low reset; standard AXI4 slave
// AW, W, B, AR, R channels with LOCAL_* widths.
module axi_mem_responder
   import axi_mem_responder_pkg::*;
#(
   parameter int LOCAL_DATA_WIDTH = 32,
   parameter int LOCAL_ADDR_WIDTH = 32,
   parameter int LOCAL_ID_WIDTH   = 2,
   parameter int MEM_DEPTH        = 1024
) (
   input  logic                            s_axi_aclk,
   input  logic                            s_axi_aresetn,
   input  logic [LOCAL_ID_WIDTH-1:0]       s_axi_awid,
   input  logic [LOCAL_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                      s_axi_awlen,
   input  logic [2:0]                      s_axi_awsize,
   input  logic [1:0]                      s_axi_awburst,
   input  logic                            s_axi_awlock,
   input  logic [3:0]                      s_axi_awcache,
   input  logic [2:0]                      s_axi_awprot,
   input  logic [3:0]                      s_axi_awqos,
   input  logic [3:0]                      s_axi_awregion,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [LOCAL_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [LOCAL_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                            s_axi_wlast,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [LOCAL_ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [LOCAL_ID_WIDTH-1:0]       s_axi_arid,
   input  logic [LOCAL_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                      s_axi_arlen,
   input  logic [2:0]                      s_axi_arsize,
   input  logic [1:0]                      s_axi_arburst,
   input  logic                            s_axi_arlock,
   input  logic [3:0]                      s_axi_arcache,
   input  logic [2:0]                      s_axi_arprot,
   input  logic [3:0]                      s_axi_arqos,
   input  logic [3:0]                      s_axi_arregion,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [LOCAL_ID_WIDTH-1:0]       s_axi_rid,
   output logic [LOCAL_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rlast,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready
);

   localparam int DW       = LOCAL_DATA_WIDTH;
   localparam int AW       = LOCAL_ADDR_WIDTH;
   localparam int STRB_W   = DW / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = $clog2(MEM_DEPTH);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic       R_IDLE = 1'b0;
   localparam logic       R_DATA = 1'b1;

   // Any address bit above the word index means the beat falls outside the memory.
   function automatic logic addr_decerr(input logic [AW-1:0] addr);
      return |(addr >> (ADDR_LSB + IDX_W));
   endfunction

   logic [DW-1:0] r_mem [MEM_DEPTH];

   // ---------------- write engine ----------------
   logic [1:0]                r_wstate;
   logic                      r_awready, r_wready, r_bvalid;
   logic [LOCAL_ID_WIDTH-1:0] r_bid;
   logic [1:0]                r_bresp;
   logic                      w_aw_hs, w_w_hs, w_b_hs;
   logic [AW-1:0]             w_waddr, w_wnext_addr;
   logic                      w_wlast, w_wlast_next, w_werr, w_wdecerr, w_wr_en;
   logic [1:0]                w_wbeat_resp;

   assign w_aw_hs   = r_awready & s_axi_awvalid;
   assign w_w_hs    = r_wready & s_axi_wvalid;
   assign w_b_hs    = r_bvalid & s_axi_bready;
   assign w_wdecerr = addr_decerr(w_waddr);
   assign w_wr_en   = w_w_hs & ~w_werr & ~w_wdecerr;

   axi_mem_addr_gen #(.ADDR_W(AW), .ADDR_LSB(ADDR_LSB)) u_wgen (
      .i_clk       (s_axi_aclk),
      .i_rst_n     (s_axi_aresetn),
      .i_load      (w_aw_hs),
      .i_addr      (s_axi_awaddr),
      .i_size      (s_axi_awsize),
      .i_burst     (s_axi_awburst),
      .i_len       (s_axi_awlen),
      .i_step      (w_w_hs),
      .o_addr      (w_waddr),
      .o_next_addr (w_wnext_addr),
      .o_last      (w_wlast),
      .o_last_next (w_wlast_next),
      .o_err       (w_werr)
   );

   // The burst always runs to beat len+1; a wlast that disagrees only degrades the response.
   always_comb begin
      w_wbeat_resp = AXI_RESP_OKAY;
      if (w_werr || (s_axi_wlast != w_wlast)) w_wbeat_resp = AXI_RESP_SLVERR;
      if (w_wdecerr)                          w_wbeat_resp = AXI_RESP_DECERR;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= AXI_RESP_OKAY;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               r_awready <= ~w_aw_hs;
               if (w_aw_hs) begin
                  r_wready <= 1'b1;
                  r_bid    <= s_axi_awid;
                  r_bresp  <= AXI_RESP_OKAY;
                  r_wstate <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_w_hs) begin
                  r_bresp <= resp_worst(r_bresp, w_wbeat_resp);
                  if (w_wlast) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_wstate <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (w_b_hs) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (w_wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) r_mem[w_waddr[ADDR_LSB +: IDX_W]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   logic                      r_rstate;
   logic                      r_arready, r_rvalid, r_rlast;
   logic [LOCAL_ID_WIDTH-1:0] r_rid;
   logic [1:0]                r_rresp;
   logic [DW-1:0]             r_rdata;
   logic                      w_ar_hs, w_r_hs;
   logic [AW-1:0]             w_raddr, w_rnext_addr, w_fetch_addr;
   logic                      w_rlast, w_rlast_next, w_rerr, w_fetch_err;
   logic [1:0]                w_fetch_resp;
   logic [DW-1:0]             w_fetch_data;

   assign w_ar_hs = r_arready & s_axi_arvalid;
   assign w_r_hs  = r_rvalid & s_axi_rready;

   axi_mem_addr_gen #(.ADDR_W(AW), .ADDR_LSB(ADDR_LSB)) u_rgen (
      .i_clk       (s_axi_aclk),
      .i_rst_n     (s_axi_aresetn),
      .i_load      (w_ar_hs),
      .i_addr      (s_axi_araddr),
      .i_size      (s_axi_arsize),
      .i_burst     (s_axi_arburst),
      .i_len       (s_axi_arlen),
      .i_step      (w_r_hs & ~r_rlast),
      .o_addr      (w_raddr),
      .o_next_addr (w_rnext_addr),
      .o_last      (w_rlast),
      .o_last_next (w_rlast_next),
      .o_err       (w_rerr)
   );

   // Beat 0 is fetched straight from the AR channel so rvalid can rise the cycle after AR;
   // later beats are fetched from the generator's next address as each beat is accepted.
   assign w_fetch_addr = w_ar_hs ? s_axi_araddr : w_rnext_addr;
   assign w_fetch_err  = w_ar_hs ? burst_err(s_axi_arburst, s_axi_arsize, 3'(ADDR_LSB)) : w_rerr;

   always_comb begin
      w_fetch_resp = AXI_RESP_OKAY;
      w_fetch_data = r_mem[w_fetch_addr[ADDR_LSB +: IDX_W]];
      if (w_fetch_err) begin
         w_fetch_resp = AXI_RESP_SLVERR;
         w_fetch_data = '0;
      end
      if (addr_decerr(w_fetch_addr)) begin
         w_fetch_resp = AXI_RESP_DECERR;
         w_fetch_data = '0;
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rid     <= '0;
         r_rresp   <= AXI_RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               r_arready <= ~w_ar_hs;
               if (w_ar_hs) begin
                  r_rvalid <= 1'b1;
                  r_rid    <= s_axi_arid;
                  r_rlast  <= (s_axi_arlen == 8'd0);
                  r_rdata  <= w_fetch_data;
                  r_rresp  <= w_fetch_resp;
                  r_rstate <= R_DATA;
               end
            end
            default: begin
               if (w_r_hs) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_rstate  <= R_IDLE;
                  end else begin
                     r_rdata <= w_fetch_data;
                     r_rresp <= w_fetch_resp;
                     r_rlast <= w_rlast_next;
                  end
               end
            end
         endcase
      end
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bid     = r_bid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_rid     = r_rid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;

   // Sideband attributes and spare generator outputs are intentionally not used.
   logic w_unused;
   assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion,
                       w_wnext_addr, w_wlast_next, w_raddr, w_rlast};

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;

   logic        clk;
   logic        aresetn;
   logic [1:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize, awprot, arprot;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awlock, arlock;
   logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion, wstrb;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;

   int checks = 0;
   int errors = 0;

   axi_mem_responder dut (
      .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
      .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
      .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awregion(awregion),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
      .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
      .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arregion(arregion),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   // ---------------- channel drivers ----------------
   task automatic aw_send(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      int n = 0;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      if (awready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL aw_timeout awready=%b required 1", awready);
         awvalid = 1'b0;
         return;
      end
      @(posedge clk); #1 awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (wready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL w_timeout wready=%b required 1", wready);
         wvalid = 1'b0;
         return;
      end
      @(posedge clk); #1 wvalid = 1'b0;
   endtask

   task automatic b_recv(output logic [1:0] resp, output logic [1:0] id);
      int n = 0;
      bready = 1'b1;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      if (bvalid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL b_timeout bvalid=%b required 1", bvalid);
         bready = 1'b0; resp = 2'bxx; id = 2'bxx;
         return;
      end
      resp = bresp; id = bid;
      @(posedge clk); #1 bready = 1'b0;
   endtask

   task automatic ar_send(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      int n = 0;
      arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
      while (!arready && n < 50) begin @(negedge clk); n++; end
      if (arready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL ar_timeout arready=%b required 1", arready);
         arvalid = 1'b0;
         return;
      end
      @(posedge clk); #1 arvalid = 1'b0;
   endtask

   task automatic r_recv(output logic [31:0] data, output logic [1:0] resp, output logic last,
                         output logic [1:0] id);
      int n = 0;
      rready = 1'b1;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (rvalid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL r_timeout rvalid=%b required 1", rvalid);
         rready = 1'b0; data = 'x; resp = 'x; last = 1'bx; id = 'x;
         return;
      end
      data = rdata; resp = rresp; last = rlast; id = rid;
      @(posedge clk); #1 rready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
         errors++;
         $display("FAIL reset_handshake got %b required 000000",
                  {awready, wready, bvalid, arready, rvalid, rlast});
      end
      checks++;
      if ({bresp, rresp, rdata, bid, rid} !== 40'h0) begin
         errors++;
         $display("FAIL reset_payload got bresp=%h rresp=%h rdata=%h bid=%h rid=%h required 0",
                  bresp, rresp, rdata, bid, rid);
      end
      aresetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({awready, arready, wready} !== 3'b110) begin
         errors++;
         $display("FAIL reset_release got aw/ar/w ready=%b required 110", {awready, arready, wready});
      end
   endtask

   task automatic test_single();
      logic [1:0] resp, id; logic [31:0] d; logic l;
      aw_send(2'd1, 32'h10, 8'd0, 2'b01);
      checks++;
      if (wready !== 1'b1) begin errors++; $display("FAIL single_wready got %b required 1", wready); end
      w_send(32'hDEADBEEF, 4'hF, 1'b1);
      checks++;
      if (bvalid !== 1'b1) begin errors++; $display("FAIL single_b_latency got %b required 1", bvalid); end
      b_recv(resp, id);
      checks++;
      if ({resp, id} !== {2'b00, 2'd1}) begin
         errors++; $display("FAIL single_bresp got resp=%h id=%h required resp=0 id=1", resp, id);
      end
      ar_send(2'd2, 32'h10, 8'd0, 2'b01);
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL single_r_latency got %b required 1", rvalid); end
      r_recv(d, resp, l, id);
      checks++;
      if ({d, resp, l, id} !== {32'hDEADBEEF, 2'b00, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL single_read got d=%h resp=%h last=%b id=%h required deadbeef 0 1 2", d, resp, l, id);
      end
      checks++;
      if (arready !== 1'b1) begin errors++; $display("FAIL single_arready_after got %b required 1", arready); end
   endtask

   task automatic test_incr();
      logic [1:0] resp, id; logic [31:0] d; logic l;
      aw_send(2'd0, 32'h100, 8'd3, 2'b01);
      for (int k = 0; k < 4; k++) w_send(32'(k + 1), 4'hF, k == 3);
      b_recv(resp, id);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %h required 0", resp); end
      ar_send(2'd3, 32'h100, 8'd3, 2'b01);
      for (int k = 0; k < 4; k++) begin
         r_recv(d, resp, l, id);
         checks++;
         if ({d, resp, l} !== {32'(k + 1), 2'b00, (k == 3)}) begin
            errors++;
            $display("FAIL incr_beat%0d got d=%h resp=%h last=%b required d=%h resp=0 last=%b",
                     k, d, resp, l, k + 1, k == 3);
         end
      end
   endtask

   task automatic test_fixed();
      logic [1:0] resp, id; logic [31:0] d; logic l;
      logic [31:0] vals [4];
      vals[0] = 32'h0A0A0A0A; vals[1] = 32'h0B0B0B0B; vals[2] = 32'h0C0C0C0C; vals[3] = 32'h0D0D0D0D;
      aw_send(2'd0, 32'h20, 8'd3, 2'b00);
      for (int k = 0; k < 4; k++) w_send(vals[k], 4'hF, k == 3);
      b_recv(resp, id);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got %h required 0", resp); end
      ar_send(2'd0, 32'h20, 8'd0, 2'b01);
      r_recv(d, resp, l, id);
      checks++;
      if ({d, resp, l} !== {32'h0D0D0D0D, 2'b00, 1'b1}) begin
         errors++; $display("FAIL fixed_read got d=%h resp=%h last=%b required 0d0d0d0d 0 1", d, resp, l);
      end
      aw_send(2'd0, 32'h20, 8'd0, 2'b01);
      w_send(32'h11223344, 4'h3, 1'b1);
      b_recv(resp, id);
      ar_send(2'd0, 32'h20, 8'd0, 2'b01);
      r_recv(d, resp, l, id);
      checks++;
      if (d !== 32'h0D0D3344) begin errors++; $display("FAIL strb_merge got %h required 0d0d3344", d); end
   endtask

   task automatic test_errors();
      logic [1:0] resp, id; logic [31:0] d; logic l;
      aw_send(2'd0, 32'hFFC, 8'd0, 2'b01);
      w_send(32'h55AA55AA, 4'hF, 1'b1);
      b_recv(resp, id);
      ar_send(2'd0, 32'hFFC, 8'd1, 2'b01);
      r_recv(d, resp, l, id);
      checks++;
      if ({d, resp, l} !== {32'h55AA55AA, 2'b00, 1'b0}) begin
         errors++; $display("FAIL straddle_beat0 got d=%h resp=%h last=%b required 55aa55aa 0 0", d, resp, l);
      end
      r_recv(d, resp, l, id);
      checks++;
      if ({d, resp, l} !== {32'h0, 2'b11, 1'b1}) begin
         errors++; $display("FAIL straddle_beat1 got d=%h resp=%h last=%b required 0 3 1", d, resp, l);
      end
      ar_send(2'd0, 32'h1000, 8'd1, 2'b01);
      for (int k = 0; k < 2; k++) begin
         r_recv(d, resp, l, id);
         checks++;
         if ({d, resp, l} !== {32'h0, 2'b11, (k == 1)}) begin
            errors++;
            $display("FAIL decerr_read%0d got d=%h resp=%h last=%b required 0 3 %b", k, d, resp, l, k == 1);
         end
      end
      aw_send(2'd0, 32'h1000, 8'd0, 2'b01);
      w_send(32'hFFFFFFFF, 4'hF, 1'b1);
      b_recv(resp, id);
      checks++;
      if (resp !== 2'b11) begin errors++; $display("FAIL decerr_write got %h required 3", resp); end
      aw_send(2'd0, 32'h10, 8'd1, 2'b10);
      w_send(32'h0, 4'hF, 1'b0);
      w_send(32'h0, 4'hF, 1'b1);
      b_recv(resp, id);
      checks++;
      if (resp !== 2'b10) begin errors++; $display("FAIL wrap_bresp got %h required 2", resp); end
      ar_send(2'd0, 32'h10, 8'd0, 2'b01);
      r_recv(d, resp, l, id);
      checks++;
      if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_no_write got %h required deadbeef", d); end
      aw_send(2'd0, 32'h40, 8'd1, 2'b01);
      w_send(32'h1, 4'hF, 1'b1);
      w_send(32'h2, 4'hF, 1'b1);
      b_recv(resp, id);
      checks++;
      if (resp !== 2'b10) begin errors++; $display("FAIL wlast_mismatch got %h required 2", resp); end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp, id;
      logic [34:0] prev;
      logic        hold;
      int          bad_b, stab_err, nb, beat_err;
      aw_send(2'd0, 32'h200, 8'd0, 2'b01);
      w_send(32'h12345678, 4'hF, 1'b1);
      bad_b = 0;
      repeat (10) begin
         @(negedge clk);
         if (bvalid !== 1'b1) bad_b++;
      end
      checks++;
      if (bad_b != 0) begin errors++; $display("FAIL bvalid_hold got %0d drops required 0", bad_b); end
      b_recv(resp, id);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL bp_bresp got %h required 0", resp); end

      ar_send(2'd1, 32'h100, 8'd3, 2'b01);
      hold = 1'b0; prev = '0; stab_err = 0; nb = 0; beat_err = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (hold && (!rvalid || {rdata, rresp, rlast} !== prev)) stab_err++;
         rready = (cyc >= 150) ? 1'b1 : 1'($urandom_range(0, 1));
         if (rvalid && rready) begin
            if ({rdata, rresp, rlast} !== {32'(nb + 1), 2'b00, (nb == 3)}) beat_err++;
            nb++;
         end
         hold = rvalid && !rready;
         prev = {rdata, rresp, rlast};
         if (rvalid && rready && rlast) begin
            @(posedge clk); #1 rready = 1'b0;
            break;
         end
      end
      rready = 1'b0;
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL r_stable got %0d changes required 0", stab_err); end
      checks++;
      if (nb != 4 || beat_err != 0) begin
         errors++; $display("FAIL r_beats got %0d beats %0d bad required 4 beats 0 bad", nb, beat_err);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp, id; logic [31:0] d; logic l;
      int bad;
      aw_send(2'd0, 32'h300, 8'd3, 2'b01);
      w_send(32'h1, 4'hF, 1'b0);
      wdata = 32'h2; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      @(negedge clk);
      aresetn = 1'b0;
      #1;
      checks++;
      if ({awready, wready, bvalid} !== 3'b000) begin
         errors++; $display("FAIL midreset_outputs got %b required 000", {awready, wready, bvalid});
      end
      wvalid = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      bready = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (bvalid !== 1'b0) bad++;
      end
      bready = 1'b0;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL midreset_no_b got %0d bvalid cycles required 0", bad); end
      aw_send(2'd2, 32'h300, 8'd0, 2'b01);
      w_send(32'hCAFEF00D, 4'hF, 1'b1);
      b_recv(resp, id);
      checks++;
      if ({resp, id} !== {2'b00, 2'd2}) begin
         errors++; $display("FAIL midreset_bresp got resp=%h id=%h required 0 2", resp, id);
      end
      ar_send(2'd0, 32'h300, 8'd0, 2'b01);
      r_recv(d, resp, l, id);
      checks++;
      if ({d, resp, l} !== {32'hCAFEF00D, 2'b00, 1'b1}) begin
         errors++; $display("FAIL midreset_read got d=%h resp=%h last=%b required cafef00d 0 1", d, resp, l);
      end
   endtask

   initial begin
      aresetn = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
      awlock = 1'b0; awcache = '0; awprot = '0; awqos = '0; awregion = '0;
      arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
      arlock = 1'b0; arcache = '0; arprot = '0; arqos = '0; arregion = '0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0; rready = 1'b0;
      test_reset();
      test_single();
      test_incr();
      test_fixed();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
